// File: rtl/div_iter.sv
// div_iter: iterative 32-bit restoring divider for MIPS DIV/DIVU.
// One quotient bit per cycle over 32 CALC cycles, then a FIX cycle
// applies signs (or the divide-by-zero result) and writes the results.
// Fixed 34-cycle latency from the accepting edge to the done pulse.
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  count_reg;
  logic [32:0] rem_reg;       // partial remainder R
  logic [31:0] quo_reg;       // dividend magnitude shifting out, quotient shifting in
  logic [31:0] dvsr_reg;      // divisor magnitude
  logic [31:0] dvnd_reg;      // dividend as captured, returned on divide-by-zero
  logic        sign_a_reg;
  logic        sign_b_reg;
  logic        zero_reg;

  logic        accept;
  logic        sign_a_in;
  logic        sign_b_in;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [33:0] shift_rem;
  logic [33:0] trial;
  logic        borrow;

  // A new request is taken only when no operation is running.
  assign accept    = start && (state_reg == IDLE || state_reg == DONE);
  assign sign_a_in = is_signed & dividend[31];
  assign sign_b_in = is_signed & divisor[31];
  assign abs_a     = sign_a_in ? -dividend : dividend;
  assign abs_b     = sign_b_in ? -divisor  : divisor;

  // R is always below the divisor after an iteration, so the shifted value
  // never sets bit 33 and trial[33] is exactly the 33-bit subtraction borrow.
  assign shift_rem = {rem_reg, quo_reg[31]};
  assign trial     = shift_rem - {2'b00, dvsr_reg};
  assign borrow    = trial[33];

  assign busy = (state_reg == CALC) || (state_reg == FIX);
  assign done = (state_reg == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; start is ignored while CALC/FIX are running.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = CALC;
      CALC: if (count_reg == 5'd31) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, restoring iterations and result write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= 5'd0;
      rem_reg    <= 33'd0;
      quo_reg    <= 32'd0;
      dvsr_reg   <= 32'd0;
      dvnd_reg   <= 32'd0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      zero_reg   <= 1'b0;
      quotient   <= 32'd0;
      remainder  <= 32'd0;
      div_zero   <= 1'b0;
    end else if (accept) begin
      count_reg  <= 5'd0;
      rem_reg    <= 33'd0;
      quo_reg    <= abs_a;
      dvsr_reg   <= abs_b;
      dvnd_reg   <= dividend;
      sign_a_reg <= sign_a_in;
      sign_b_reg <= sign_b_in;
      zero_reg   <= (divisor == 32'd0);
    end else if (state_reg == CALC) begin
      rem_reg   <= borrow ? shift_rem[32:0] : trial[32:0];
      quo_reg   <= {quo_reg[30:0], ~borrow};
      count_reg <= count_reg + 5'd1;
    end else if (state_reg == FIX) begin
      if (zero_reg) begin
        quotient  <= 32'hFFFF_FFFF;
        remainder <= dvnd_reg;
      end else begin
        quotient  <= (sign_a_reg ^ sign_b_reg) ? -quo_reg : quo_reg;
        remainder <= sign_a_reg ? -rem_reg[31:0] : rem_reg[31:0];
      end
      div_zero <= zero_reg;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and randomized checks of div_iter against a plain
// arithmetic reference model (64-bit signed math avoids the INT_MIN/-1 trap).
module tb_div_iter;
  logic        clk = 1'b0;
  logic        rst, start, is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] prev_q = 32'd0;
  logic [31:0] prev_r = 32'd0;

  div_iter dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output bit z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb); r = 32'(sa % sb); z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Drive a request and return right after the accepting edge (start still high).
  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clk);
  endtask

  // Follow one operation to done and check latency, busy span and results.
  task automatic finish_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input bit glitch, input bit chain,
                           input bit sgn2, input logic [31:0] a2, input logic [31:0] b2);
    logic [31:0] eq, er;
    bit ez;
    int cyc = 0;
    int busy_n = 0;
    bit seen = 1'b0;
    model(sgn, a, b, eq, er, ez);
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        check("hold_q", quotient, prev_q);
        check("hold_r", remainder, prev_r);
      end
      if (glitch && cyc == 5) begin
        start = 1'b1; dividend = $urandom; divisor = $urandom_range(0, 3);
      end
      if (glitch && cyc == 6) start = 1'b0;
      if (busy) busy_n++;
      if (done) seen = 1'b1;
    end
    check("latency", 32'(cyc), 32'd34);
    check("busy_cycles", 32'(busy_n), 32'd33);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_zero", {31'd0, div_zero}, {31'd0, ez});
    $display("[TB] %s %h / %h -> q=%h r=%h z=%0d lat=%0d",
             sgn ? "DIV " : "DIVU", a, b, quotient, remainder, div_zero, cyc);
    prev_q = eq; prev_r = er;
    if (chain) begin
      start = 1'b1; is_signed = sgn2; dividend = a2; divisor = b2;
      @(posedge clk);
    end
  endtask

  logic [31:0] ta [8] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF,
                          32'h8000_0000, 32'd3, 32'd5, 32'h8000_0000};
  logic [31:0] tb [8] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd1,
                          32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
  bit          ts [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int dn;
    bit sgn;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_z", {31'd0, div_zero}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      issue(ts[i], ta[i], tb[i]);
      finish_op(ts[i], ta[i], tb[i], 1'b0, 1'b0, 1'b0, '0, '0);
    end

    // start pulsed with new operands mid-CALC must be ignored.
    issue(1'b0, 32'd1000, 32'd13);
    finish_op(1'b0, 32'd1000, 32'd13, 1'b1, 1'b0, 1'b0, '0, '0);
    dn = 0;
    repeat (40) begin @(negedge clk); if (done) dn++; end
    check("no_extra_done", 32'(dn), 32'd0);

    // Back-to-back: start held through DONE.
    issue(1'b1, 32'd12345, 32'hFFFF_FFEF);
    finish_op(1'b1, 32'd12345, 32'hFFFF_FFEF, 1'b0, 1'b1, 1'b0, 32'd999, 32'd10);
    finish_op(1'b0, 32'd999, 32'd10, 1'b0, 1'b0, 1'b0, '0, '0);

    for (int i = 0; i < 25; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin sgn = 1'b1; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      issue(sgn, a, b);
      finish_op(sgn, a, b, 1'b0, 1'b0, 1'b0, '0, '0);
    end

    // Reset mid-operation drops the result and never pulses done.
    issue(1'b0, 32'd5000, 32'd3);
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_q", quotient, 32'd0);
    check("mid_rst_r", remainder, 32'd0);
    dn = 0;
    repeat (50) begin @(negedge clk); if (done) dn++; end
    check("mid_rst_no_done", 32'(dn), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit integer divider for the EX stage, alongside the 32-bit add/subtract unit. It implements MIPS DIV/DIVU by restoring division, one quotient bit per cycle, using a 33-bit trial subtraction whose borrow follows the add/subtract unit's CF convention. Its quotient and remainder feed the LO and HI write path. A start/busy/done handshake lets the pipeline stall while the divider runs.

## Interface
Parameters:
- none (width fixed at 32)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a divide; sampled only in IDLE or DONE
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU
- dividend  in  32  numerator; sampled with start
- divisor  in  32  denominator; sampled with start
- busy  out  1  high in CALC and FIX
- done  out  1  one-cycle pulse; results valid from this cycle onward
- quotient  out  32  to LO
- remainder  out  32  to HI
- div_zero  out  1  set with done when divisor was 0; held with results

## Operation
- States: IDLE, CALC, FIX, DONE. Reset enters IDLE.
- Transitions:
  - IDLE or DONE with start=1: go to CALC.
  - DONE with start=0: go to IDLE.
  - CALC: stays for exactly 32 cycles, counted by a 5-bit counter. At count 31, go to FIX.
  - FIX: always goes to DONE.
- Capture (on the accepting edge):
  - latch is_signed, sign_a = is_signed & dividend[31], sign_b = is_signed & divisor[31], zero flag = (divisor == 0).
  - load the work registers with magnitudes: |dividend| and |divisor| when signed; raw operands otherwise.
  - clear the partial remainder R (33 bits).
- CALC iteration, MSB first:
  - {R, Q} <<= 1.
  - D = R - {1'b0, |divisor|}, computed 33 bits wide.
  - No borrow: R = D and Q[0] = 1. Borrow: R is unchanged and Q[0] = 0.
- FIX, normal divisor:
  - quotient = (sign_a ^ sign_b) ? -Q : Q.
  - remainder = sign_a ? -R[31:0] : R[31:0]. The remainder takes the dividend's sign.
- FIX, zero divisor:
  - quotient = 32'hFFFFFFFF, remainder = dividend as originally captured, div_zero = 1, for both signed and unsigned.
- Signed 0x80000000 / -1: quotient = 0x80000000, remainder = 0. No flag is raised.
- quotient, remainder and div_zero are written only in FIX. They hold until the next FIX.
- start in CALC or FIX is ignored and has no effect on the running operation.
- Operand inputs may change freely after the accepting edge.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_zero=0, state IDLE, counter 0.
- Cycle numbering, with start accepted at edge T:
  - cycles T+1 .. T+32: CALC, busy=1.
  - cycle T+33: FIX, busy=1.
  - cycle T+34: DONE, done=1, busy=0, new results visible.
- Fixed latency of 34 cycles from the accepting edge to done, independent of operand values or divide-by-zero.
- Back-to-back: start held high in DONE begins the next operation at the next edge, so throughput is 1 per 34 cycles. The previous results remain visible until the next FIX.
- rst asserted in any state: the next edge returns to IDLE with all outputs at reset values. The in-flight operation is dropped with no done.
- rst and start asserted together: rst wins.

## Test plan
- Unsigned basic: DIVU 100 / 7 -> done exactly 34 cycles after the start edge; quotient=14, remainder=2, div_zero=0. busy=1 for exactly 33 cycles.
- Signed signs: DIV -7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. DIV 7 / -2 -> quotient=0xFFFFFFFD, remainder=1.
- Extremes:
  - DIVU 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
  - DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
  - DIVU 3 / 0xFFFFFFFF -> quotient=0, remainder=3.
- Divide by zero: DIV 5 / 0 and DIVU 0x80000000 / 0 -> quotient=0xFFFFFFFF, remainder=dividend, div_zero=1, same 34-cycle latency.
- Handshake:
  - change operands and pulse start during CALC -> results match the first operands; no extra done.
  - hold start through DONE -> the second operation completes 34 cycles later.
- Reset mid-operation: assert rst at cycle T+10 -> next cycle busy=0, quotient=0, remainder=0; no done ever appears for that operation.
